// File: rtl/twiddle_addr_gen_pkg.sv
// ---------------------------------------------------------------------------
// twiddle_addr_gen_pkg
// Shared definitions for the twiddle address generator and the FFT control
// FSM: sequencer state encoding, default transform geometry and the derived
// widths that both sides agree on.
// ---------------------------------------------------------------------------
package twiddle_addr_gen_pkg;

    // Default transform geometry (1024-point radix-2 DIT)
    localparam int FFT_N     = 1024;
    localparam int FFT_LOG2N = 10;

    // Number of butterflies per stage, which is also the twiddle ROM depth
    localparam int HALF_N  = FFT_N / 2;
    // Width of a stage index
    localparam int STAGE_W = $clog2(FFT_LOG2N);

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/twiddle_index_calc.sv
// ---------------------------------------------------------------------------
// twiddle_index_calc
// Combinational twiddle index for radix-2 DIT:
//     k = (j mod 2^s) << (LOG2N-1-s)
// built from a mask and a shifter so no multiplier is needed.
//
// Ports:
//   s  in   stage index, 0..LOG2N-1
//   j  in   butterfly index within the stage, 0..N/2-1
//   k  out  twiddle ROM index, always < N/2
// ---------------------------------------------------------------------------
module twiddle_index_calc
    import twiddle_addr_gen_pkg::*;
#(
    parameter int LOG2N = FFT_LOG2N,
    parameter int S_W   = $clog2(LOG2N)
) (
    input  logic [S_W-1:0]   s,
    input  logic [LOG2N-2:0] j,
    output logic [LOG2N-2:0] k
);

    localparam int J_W = LOG2N - 1;

    logic [J_W-1:0] mask;
    logic [S_W-1:0] shamt;

    // mask keeps the low s bits of j (j mod 2^s); shifting a full-ones
    // vector left by s clears exactly those bits before inversion. The
    // kept bits are then moved up so that k spans the full ROM range in
    // the last stage and collapses to 0 in the first.
    always_comb begin
        mask  = ~({J_W{1'b1}} << s);
        shamt = S_W'(J_W) - s;
        k     = (j & mask) << shamt;
    end

endmodule

// File: rtl/twiddle_addr_gen.sv
// ---------------------------------------------------------------------------
// twiddle_addr_gen
// Walks all LOG2N stages x N/2 butterflies of a radix-2 DIT FFT, drives the
// twiddle ROM address for each butterfly and raises tw_valid in the cycle
// the ROM's registered W_re/W_im output holds that twiddle.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle pulse, starts a transform when idle
//   ready     in   butterfly datapath accepts a twiddle this cycle
//   address   out  twiddle ROM read address
//   tw_valid  out  ROM output is a new, valid twiddle this cycle
//   stage_o   out  stage index aligned with tw_valid
//   bfly_o    out  butterfly index aligned with tw_valid
//   busy      out  sequence in progress (RUN or DRAIN)
//   done      out  one-cycle pulse after the last twiddle is presented
// ---------------------------------------------------------------------------
module twiddle_addr_gen
    import twiddle_addr_gen_pkg::*;
#(
    parameter int N      = FFT_N,
    parameter int LOG2N  = FFT_LOG2N,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     ready,
    output logic [ADDR_W-1:0]        address,
    output logic                     tw_valid,
    output logic [$clog2(LOG2N)-1:0] stage_o,
    output logic [LOG2N-2:0]         bfly_o,
    output logic                     busy,
    output logic                     done
);

    localparam int S_W = $clog2(LOG2N);
    localparam int J_W = LOG2N - 1;

    localparam logic [S_W-1:0] S_LAST = S_W'(LOG2N - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(N / 2 - 1);

    state_t         state;
    logic [S_W-1:0] s;
    logic [J_W-1:0] j;
    logic [J_W-1:0] k;

    logic           issue;
    logic           last_issue;

    // First alignment stage, parallel to the address register
    logic           iss_d1;
    logic [S_W-1:0] s_d1;
    logic [J_W-1:0] j_d1;

    assign issue      = (state == RUN) && ready;
    assign last_issue = issue && (s == S_LAST) && (j == J_LAST);

    twiddle_index_calc #(
        .LOG2N (LOG2N),
        .S_W   (S_W)
    ) u_index_calc (
        .s (s),
        .j (j),
        .k (k)
    );

    // Sequencer: owns the stage/butterfly counters, the ROM address and the
    // busy/done handshake with the FFT control. A stalled RUN cycle changes
    // nothing, so the ROM keeps re-reading the same address.
    // DRAIN leaves once the final issue has moved past the first alignment
    // register; that edge loads the last tw_valid, so done lands in the
    // cycle right after it. done is high while already in IDLE, hence the
    // explicit guard that ignores a start arriving alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s       <= '0;
            j       <= '0;
            address <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        state <= RUN;
                        s     <= '0;
                        j     <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        address <= ADDR_W'(k);
                        if (last_issue) begin
                            state <= DRAIN;
                            s     <= '0;
                            j     <= '0;
                        end else if (j == J_LAST) begin
                            j <= '0;
                            s <= s + S_W'(1);
                        end else begin
                            j <= j + J_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!iss_d1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Two-register alignment of the issue strobe and its indices: the first
    // register matches the address register, the second matches the ROM's
    // output register. Indices are captured only on an issue so the outputs
    // keep describing the most recent twiddle between pulses. Reset clears
    // everything in flight, so no stale tw_valid escapes after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_d1   <= 1'b0;
            s_d1     <= '0;
            j_d1     <= '0;
            tw_valid <= 1'b0;
            stage_o  <= '0;
            bfly_o   <= '0;
        end else begin
            iss_d1 <= issue;
            if (issue) begin
                s_d1 <= s;
                j_d1 <= j;
            end
            tw_valid <= iss_d1;
            stage_o  <= s_d1;
            bfly_o   <= j_d1;
        end
    end

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_twiddle_addr_gen
// Scoreboard bench: expected twiddles are queued when a transform is started,
// and per-DUT monitors pop and compare them whenever tw_valid is seen. A tiny
// ROM model (registered copy of address) stands in for the twiddle ROM.
// DUTs: an N=8 generator, a default N=1024 generator and an N=16 index calc.
// ---------------------------------------------------------------------------
module tb_twiddle_addr_gen;

    typedef struct {
        int s;
        int j;
        int k;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        start8;
    logic        ready8;
    logic [15:0] address8;
    logic        tw_valid8;
    logic [1:0]  stage8;
    logic [1:0]  bfly8;
    logic        busy8;
    logic        done8;

    logic        start_big;
    logic        ready_big;
    logic [15:0] address_big;
    logic        tw_valid_big;
    logic [3:0]  stage_big;
    logic [8:0]  bfly_big;
    logic        busy_big;
    logic        done_big;

    logic [1:0]  s16;
    logic [2:0]  j16;
    logic [2:0]  k16;

    logic [15:0] rom8;
    logic [15:0] rom_big;

    exp_t exp8[$];
    exp_t exp_big[$];
    exp_t e8;
    exp_t eb;

    int checks       = 0;
    int failures     = 0;
    int tw_cnt8      = 0;
    int done_cnt8    = 0;
    int tw_cnt_big   = 0;
    int done_cnt_big = 0;
    int busy_cyc_big = 0;
    logic prev_tw8    = 1'b0;
    logic prev_tw_big = 1'b0;

    // Hand-computed N=8 address order: stage 0, stage 1, stage 2
    int k8_table[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    twiddle_addr_gen #(.N(8), .LOG2N(3), .ADDR_W(16)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start8),
        .ready    (ready8),
        .address  (address8),
        .tw_valid (tw_valid8),
        .stage_o  (stage8),
        .bfly_o   (bfly8),
        .busy     (busy8),
        .done     (done8)
    );

    twiddle_addr_gen dut_big (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_big),
        .ready    (ready_big),
        .address  (address_big),
        .tw_valid (tw_valid_big),
        .stage_o  (stage_big),
        .bfly_o   (bfly_big),
        .busy     (busy_big),
        .done     (done_big)
    );

    twiddle_index_calc #(.LOG2N(4), .S_W(2)) dut_idx (
        .s (s16),
        .j (j16),
        .k (k16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Twiddle ROM stand-in: one cycle of latency, data equals the address
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom8    <= '0;
            rom_big <= '0;
        end else begin
            rom8    <= address8;
            rom_big <= address_big;
        end
    end

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", name, act, expv);
        end
    endtask

    // which=0 pulses the N=8 generator, which=1 the default one
    task automatic applyStimulus(input bit which);
        @(posedge clk);
        #2;
        if (which) start_big = 1'b1;
        else       start8    = 1'b1;
        @(posedge clk);
        #2;
        start_big = 1'b0;
        start8    = 1'b0;
    endtask

    task automatic pushSeq8();
        for (int i = 0; i < 12; i++) begin
            exp8.push_back('{i / 4, i % 4, k8_table[i]});
        end
    endtask

    // Returns at the falling edge inside the done cycle
    task automatic waitDone8(input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        if (!seen) checkOutput("wait_done8_timeout", 0, 1);
    endtask

    // N=8 monitor
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_tw8 = 1'b0;
        end else begin
            if (tw_valid8) begin
                tw_cnt8++;
                if (exp8.size() == 0) begin
                    checkOutput("unexpected_tw_valid8", 1, 0);
                end else begin
                    e8 = exp8.pop_front();
                    checkOutput("rom_addr8", rom8, e8.k);
                    checkOutput("stage8", stage8, e8.s);
                    checkOutput("bfly8", bfly8, e8.j);
                end
            end
            if (done8) begin
                done_cnt8++;
                checkOutput("done8_after_last_tw", prev_tw8, 1);
                checkOutput("done8_queue_empty", exp8.size(), 0);
            end
            prev_tw8 = tw_valid8;
        end
    end

    // Default-size monitor
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_tw_big = 1'b0;
        end else begin
            if (busy_big) busy_cyc_big++;
            if (tw_valid_big) begin
                tw_cnt_big++;
                if (exp_big.size() == 0) begin
                    checkOutput("unexpected_tw_valid_big", 1, 0);
                end else begin
                    eb = exp_big.pop_front();
                    checkOutput("rom_addr_big", rom_big, eb.k);
                    checkOutput("stage_big", stage_big, eb.s);
                    checkOutput("bfly_big", bfly_big, eb.j);
                end
            end
            if (done_big) begin
                done_cnt_big++;
                checkOutput("done_big_after_last_tw", prev_tw_big, 1);
            end
            prev_tw_big = tw_valid_big;
        end
    end

    initial begin
        int base_tw;
        int base_done;
        int a_before;
        bit seen;

        rst_n     = 1'b0;
        start8    = 1'b0;
        ready8    = 1'b1;
        start_big = 1'b0;
        ready_big = 1'b1;
        s16       = '0;
        j16       = '0;

        #12;
        checkOutput("reset_address", address8, 0);
        checkOutput("reset_tw_valid", tw_valid8, 0);
        checkOutput("reset_stage", stage8, 0);
        checkOutput("reset_bfly", bfly8, 0);
        checkOutput("reset_busy", busy8, 0);
        checkOutput("reset_done", done8, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Scenario 1: ready high, exact tw_valid/done timing
        $display("[TB] scenario 1: N=8 ready high");
        base_tw   = tw_cnt8;
        base_done = done_cnt8;
        pushSeq8();
        applyStimulus(1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput($sformatf("s1_tw_valid_c%0d", i), tw_valid8, int'(i >= 2 && i <= 13));
            checkOutput($sformatf("s1_done_c%0d", i), done8, int'(i == 14));
        end
        checkOutput("s1_tw_count", tw_cnt8 - base_tw, 12);
        checkOutput("s1_done_count", done_cnt8 - base_done, 1);
        checkOutput("s1_queue_empty", exp8.size(), 0);

        // Scenario 2 (N=8 variant): ready pattern 1,0,0 with address hold
        $display("[TB] scenario 3: N=8 ready stalls");
        base_tw   = tw_cnt8;
        base_done = done_cnt8;
        pushSeq8();
        applyStimulus(1'b0);
        for (int c = 0; c < 80 && done_cnt8 == base_done; c++) begin
            ready8   = (c % 3 == 0);
            a_before = int'(address8);
            @(posedge clk);
            #2;
            if (!ready8) checkOutput("s3_addr_hold", address8, a_before);
        end
        ready8 = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("s3_done_count", done_cnt8 - base_done, 1);
        checkOutput("s3_tw_count", tw_cnt8 - base_tw, 12);
        checkOutput("s3_queue_empty", exp8.size(), 0);

        // Scenario 4: start during RUN and on the done cycle is ignored
        $display("[TB] scenario 4: stray start pulses");
        base_tw   = tw_cnt8;
        base_done = done_cnt8;
        pushSeq8();
        applyStimulus(1'b0);
        repeat (4) @(posedge clk);
        #2 start8 = 1'b1;
        @(posedge clk);
        #2 start8 = 1'b0;
        waitDone8(100);
        start8 = 1'b1;
        @(posedge clk);
        #2 start8 = 1'b0;
        @(negedge clk);
        checkOutput("s4_start_on_done_ignored", busy8, 0);
        checkOutput("s4_first_done_count", done_cnt8 - base_done, 1);
        pushSeq8();
        applyStimulus(1'b0);
        waitDone8(100);
        repeat (2) @(negedge clk);
        checkOutput("s4_done_count", done_cnt8 - base_done, 2);
        checkOutput("s4_tw_count", tw_cnt8 - base_tw, 24);
        checkOutput("s4_queue_empty", exp8.size(), 0);

        // Scenario 5: asynchronous reset at stage 1, j=2
        $display("[TB] scenario 5: reset mid-transform");
        base_done = done_cnt8;
        pushSeq8();
        applyStimulus(1'b0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        exp8.delete();
        #1;
        checkOutput("s5_rst_address", address8, 0);
        checkOutput("s5_rst_tw_valid", tw_valid8, 0);
        checkOutput("s5_rst_stage", stage8, 0);
        checkOutput("s5_rst_bfly", bfly8, 0);
        checkOutput("s5_rst_busy", busy8, 0);
        checkOutput("s5_rst_done", done8, 0);
        base_tw = tw_cnt8;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("s5_no_tw_after_reset", tw_cnt8 - base_tw, 0);
        checkOutput("s5_no_done_after_reset", done_cnt8 - base_done, 0);
        pushSeq8();
        applyStimulus(1'b0);
        waitDone8(100);
        repeat (2) @(negedge clk);
        checkOutput("s5_restart_tw_count", tw_cnt8 - base_tw, 12);
        checkOutput("s5_restart_done_count", done_cnt8 - base_done, 1);
        checkOutput("s5_queue_empty", exp8.size(), 0);

        // Scenario 6: exhaustive index calc for N=16
        $display("[TB] scenario 6: index calc N=16");
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 8; j++) begin
                s16 = 2'(s);
                j16 = 3'(j);
                #1;
                checkOutput($sformatf("idx_s%0d_j%0d", s, j), k16,
                            (j % (1 << s)) * (16 >> (s + 1)));
            end
        end

        // Scenario 2: full default transform against the reference model
        $display("[TB] scenario 2: N=1024 ready high");
        for (int s = 0; s < 10; s++) begin
            for (int j = 0; j < 512; j++) begin
                exp_big.push_back('{s, j, (j % (1 << s)) * (1024 >> (s + 1))});
            end
        end
        applyStimulus(1'b1);
        seen = 1'b0;
        for (int c = 0; c < 6000 && !seen; c++) begin
            @(negedge clk);
            if (done_big) seen = 1'b1;
        end
        if (!seen) checkOutput("wait_done_big_timeout", 0, 1);
        repeat (2) @(negedge clk);
        checkOutput("s2_tw_count", tw_cnt_big, 5120);
        checkOutput("s2_busy_cycles", busy_cyc_big, 5122);
        checkOutput("s2_done_count", done_cnt_big, 1);
        checkOutput("s2_queue_empty", exp_big.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/twiddle_addr_gen.md
Name: twiddle_addr_gen

Overview:
Initiator side of the twiddle-factor ROM read interface. It sequences radix-2 DIT FFT stages and butterflies. For each butterfly it drives the ROM address and produces a valid strobe aligned with the ROM's registered W_re/W_im output, so the butterfly datapath samples twiddles without its own address logic. It sits between the FFT control FSM (start/done) and the twiddle ROM plus butterfly unit.

Parameters:
N, 1024, FFT length (power of two, >= 4); ROM depth is N/2.
LOG2N, 10, log2(N); number of stages.
ADDR_W, 16, ROM address width (must satisfy 2^ADDR_W >= N/2).

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a full transform sequence when idle
ready  in  1  butterfly datapath can accept a twiddle this cycle
address  out  ADDR_W  twiddle ROM read address
tw_valid  out  1  ROM output (W_re/W_im) this cycle is a new, valid twiddle
stage_o  out  $clog2(LOG2N)  stage index aligned with tw_valid
bfly_o  out  LOG2N-1  butterfly index j aligned with tw_valid
busy  out  1  sequence in progress (RUN or DRAIN)
done  out  1  one-cycle pulse after the last twiddle is presented

Behaviour:
- Reset (async, rst_n=0): state IDLE; address=0, tw_valid=0, stage_o=0, bfly_o=0, busy=0, done=0; internal counters s=0, j=0.
- Address rule: for stage s (0..LOG2N-1) and butterfly j (0..N/2-1), k = (j mod 2^s) << (LOG2N-1-s). k is always < N/2. Compute it with a mask and shift, not a multiplier. Zero-extend k to ADDR_W.
- Issue: an issue occurs on any RUN cycle with ready=1. On an issue, address is registered with k(s,j) and the counters advance: j+1, or j=0 and s+1 when j=N/2-1.
- Stall: with ready=0 in RUN, address, s and j hold. The ROM re-reads the same address, so its output stays stable.
- Alignment: the ROM adds 1 cycle of latency. tw_valid, stage_o and bfly_o are the issue strobe, s and j delayed by exactly 2 registers (address register + ROM register). tw_valid is high for exactly one cycle per issued address.
- FSM:
  - IDLE: start=1 -> RUN with s=0, j=0, busy=1. Otherwise stay.
  - RUN: the issue of (s=LOG2N-1, j=N/2-1) -> DRAIN.
  - DRAIN: wait until the final tw_valid has been emitted (2 cycles), then pulse done for 1 cycle (coincident with the cycle after the last tw_valid) and go to IDLE with busy=0.
- start while busy: ignored. start in the same cycle done pulses: ignored; a new start is accepted from the next IDLE cycle.
- Total issues per transform: LOG2N*N/2 (5120 for defaults). With ready tied high, RUN lasts exactly LOG2N*N/2 cycles.
- Reset mid-operation: immediate return to IDLE with reset values. No done pulse and no further tw_valid, including any in flight.
- ready has no effect outside RUN.

Decomposition:
- Shared package: a state encoding typedef (IDLE, RUN, DRAIN) and localparams HALF_N=N/2 and STAGE_W=$clog2(LOG2N), reused by the FFT control FSM.
- One natural sub-module: twiddle_index_calc, a combinational k(s,j) mask/shift with ports s, j and k. It is kept separate so the verification engineer can exhaustively check it against a reference model.
- Counters, FSM and the alignment pipeline stay in the top module.

Test Plan:
1. N=8, LOG2N=3, ready=1, pulse start -> address sequence over 12 issue cycles is 0,0,0,0, 0,2,0,2, 0,1,2,3. tw_valid is high 12 consecutive cycles starting 2 cycles after the first issue. done pulses once after the 12th tw_valid.
2. Defaults, ready=1 -> 5120 tw_valid pulses total. Stage 9 addresses run 0..511 in order. stage_o/bfly_o match the address at every tw_valid (compared against the model k).
3. N=8, ready toggles 1,0,0,1,... -> address holds during ready=0. Exactly 12 tw_valid pulses, no duplicates, and the same address order as scenario 1.
4. Extra start pulses during RUN and on the done cycle -> ignored. A single done pulse. The next start, applied 1 cycle later, restarts cleanly from address 0.
5. rst_n deasserted for 1 cycle at stage 1, j=2 -> all outputs return to 0 asynchronously. No done pulse and no tw_valid after reset. A subsequent start produces the full scenario 1 sequence.
6. twiddle_index_calc exhaustive for N=16: all (s,j) -> k equals (j mod 2^s)*(N/2^(s+1)) and k < 8.
